rv32i_instr_encoder: RTL and testbench
======================================

Name: rv32i_instr_encoder

Overview:
- Inverse of the control-unit decode path: accepts decoded RV32I instruction fields and assembles legal 32-bit instruction words.
- Words are buffered in a small FIFO and drained over a valid/ready stream.
- Sits in front of instruction memory preload and bench stimulus paths, so programs are built from fields instead of hand-coded hex.
- Flags out-of-range immediates and illegal formats per word; keeps running totals of encoded and rejected instructions.

Parameters:
- DEPTH, 4, output FIFO entries (power of two, ≥2)
- CNT_W, 16, width of the enc_cnt and err_cnt counters

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept (FIFO not full)
- fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
- opcode  input  7  opcode[6:0]
- funct3  input  3  funct3
- funct7  input  7  funct7 (R; I-shift upper bits)
- rd  input  5  destination register
- rs1  input  5  source register 1
- rs2  input  5  source register 2
- imm  input  32  signed byte-offset/immediate, full width
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- instr  output  32  encoded word at FIFO head
- out_err  output  1  head entry was rejected
- enc_cnt  output  CNT_W  words accepted since reset, saturating
- err_cnt  output  CNT_W  rejected words since reset, saturating

Behaviour:
- Reset:
  - Empties the FIFO: out_valid=0, in_ready=1, instr=0, out_err=0, enc_cnt=0, err_cnt=0.
  - Reset mid-stream discards all queued entries; an accept in the reset cycle is dropped.
- Accept: in_valid & in_ready at edge N encodes combinationally and writes one entry {err, instr}.
- Latency: entry visible on instr/out_valid from cycle N+1 when FIFO was empty; no input-to-output bypass.
- Pop: out_valid & out_ready removes the head.
- Push and pop in the same cycle: count unchanged, data order preserved.
- Full: in_ready = (count != DEPTH), registered from the count. No push while full, even if a pop occurs the same cycle.
- Empty: out_valid=0; instr and out_err hold their last value, don't-care.
- Encodings:
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode. If opcode=0010011 and funct3 is 001 or 101 (shift), bits[31:25]=funct7 and bits[24:20]=imm[4:0].
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
- Error conditions, any of which sets err:
  - fmt 6/7
  - I non-shift or S with imm outside [-2048, 2047]
  - I shift with imm outside [0, 31]
  - B with imm outside [-4096, 4094] or imm[0]=1
  - U with imm[11:0]≠0
  - J with imm outside [-1048576, 1048574] or imm[0]=1
- Errored entries store instr=32'h00000013 (NOP) with err=1; they still occupy a slot and are delivered in order.
- Counters:
  - enc_cnt increments on every accept.
  - err_cnt increments on every errored accept.
  - Both saturate at all-ones.
- FIFO pointers are log2(DEPTH) bits with natural wrap.

Test Plan:
- After reset, push R{opcode=0110011,f3=000,f7=0000000,rd=3,rs1=1,rs2=2} with out_ready=1 → next cycle instr=0x002081B3, out_err=0, enc_cnt=1. Repeat with f7=0100000 → 0x402081B3.
- With out_ready=0, push ADDI x1,x0,5 / SW x2,8(x1) / BEQ x1,x2,+8 / LUI x5,0x12345000 → in_ready=0 after the 4th push. Then set out_ready=1 → drains in order 0x00500093, 0x0020A423, 0x00208463, 0x123452B7. out_valid drops the cycle after the last pop.
- JAL x1,+16 → 0x010000EF. SRAI x1,x1,3 (f7=0100000) → 0x4030D093.
- Errors: B imm=7, I imm=4096, U imm=0x1001, fmt=6 → four entries, each instr=0x00000013, out_err=1. err_cnt=4, enc_cnt incremented by 4.
- FIFO full with continuous out_ready=1 and in_valid=1 → one word in / one word out per cycle after fill, no loss or duplication across pointer wrap (≥3×DEPTH words).
- Assert rst for one cycle while 3 entries are queued and in_valid=1 → out_valid=0, counters 0, pushed word dropped. The next push appears alone at the head.

Source files
------------

// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder: assembles RV32I words from decoded fields into a valid/ready FIFO
module rv32i_instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       fmt,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [32:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             ready_q;
    logic [CNT_W-1:0] enc_q, err_q;
    logic             push, pop, err, shift;
    logic [31:0]      word;
    logic signed [31:0] simm;

    always_comb begin
        simm  = imm;
        shift = opcode == 7'b0010011 && (funct3 == 3'b001 || funct3 == 3'b101);
        word  = NOP;
        err   = 1'b0;
        case (fmt)
            3'd0: word = {funct7, rs2, rs1, funct3, rd, opcode};
            3'd1: begin
                word = {shift ? funct7 : imm[11:5], imm[4:0], rs1, funct3, rd, opcode};
                err  = shift ? (imm > 32'd31) : (simm < -2048 || simm > 2047);
            end
            3'd2: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err  = simm < -2048 || simm > 2047;
            end
            3'd3: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err  = simm < -4096 || simm > 4094 || imm[0];
            end
            3'd4: begin
                word = {imm[31:12], rd, opcode};
                err  = |imm[11:0];
            end
            3'd5: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err  = simm < -1048576 || simm > 1048574 || imm[0];
            end
            default: err = 1'b1;
        endcase
    end

    assign push  = in_valid & ready_q;
    assign pop   = out_ready & (cnt_q != '0);
    assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            enc_q   <= '0;
            err_q   <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= {err, err ? NOP : word};
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q   <= cnt_d;
            ready_q <= cnt_d != (AW+1)'(DEPTH);
            if (push && !(&enc_q)) enc_q <= enc_q + 1'b1;
            if (push && err && !(&err_q)) err_q <= err_q + 1'b1;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = cnt_q != '0;
    assign instr     = mem_q[rd_q][31:0];
    assign out_err   = mem_q[rd_q][32];
    assign enc_cnt   = enc_q;
    assign err_cnt   = err_q;
endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb_rv32i_instr_encoder: randomized and directed checks against a field-level reference model
module tb_rv32i_instr_encoder;
    localparam int DEPTH = 4;
    localparam int CW    = 5;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [2:0] fmt = 0, funct3 = 0;
    logic [6:0] opcode = 0, funct7 = 0;
    logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
    logic [31:0] imm = 0;
    logic in_ready, out_valid, out_err;
    logic [31:0] instr;
    logic [CW-1:0] enc_cnt, err_cnt;

    logic [32:0] q[$];
    int enc_m = 0, err_m = 0;
    int checks = 0, errors = 0;

    rv32i_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
        .out_err(out_err), .enc_cnt(enc_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bits(logic [31:0] v, int lo, int n);
        return (v >> lo) & ((32'd1 << n) - 32'd1);
    endfunction

    // Reference encoder built from field arithmetic and integer range rules
    function automatic logic [32:0] ref_enc(logic [31:0] f, logic [31:0] op, logic [31:0] f3,
        logic [31:0] f7, logic [31:0] d, logic [31:0] s1, logic [31:0] s2, logic [31:0] im);
        int s;
        bit e, sh;
        logic [31:0] w;
        s  = $signed(im);
        sh = (op == 32'h13) && (f3 == 1 || f3 == 5);
        e  = 0;
        w  = 0;
        case (f)
            0: w = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
            1: begin
                w = (sh ? ((f7 << 25) | (bits(im, 0, 5) << 20)) : (bits(im, 0, 12) << 20))
                    | (s1 << 15) | (f3 << 12) | (d << 7) | op;
                e = sh ? (s < 0 || s > 31) : (s < -2048 || s > 2047);
            end
            2: begin
                w = (bits(im, 5, 7) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (bits(im, 0, 5) << 7) | op;
                e = s < -2048 || s > 2047;
            end
            3: begin
                w = (bits(im, 12, 1) << 31) | (bits(im, 5, 6) << 25) | (s2 << 20) | (s1 << 15)
                    | (f3 << 12) | (bits(im, 1, 4) << 8) | (bits(im, 11, 1) << 7) | op;
                e = s < -4096 || s > 4094 || (s % 2) != 0;
            end
            4: begin
                w = (im / 4096) * 4096 + (d << 7) + op;
                e = (im % 4096) != 0;
            end
            5: begin
                w = (bits(im, 20, 1) << 31) | (bits(im, 1, 10) << 21) | (bits(im, 11, 1) << 20)
                    | (bits(im, 12, 8) << 12) | (d << 7) | op;
                e = s < -1048576 || s > 1048574 || (s % 2) != 0;
            end
            default: e = 1;
        endcase
        return {e, e ? 32'h13 : w};
    endfunction

    task automatic drive(int f, int op, int f3, int f7, int d, int s1, int s2, logic [31:0] im);
        in_valid = 1;
        fmt = 3'(f); opcode = 7'(op); funct3 = 3'(f3); funct7 = 7'(f7);
        rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = im;
    endtask

    task automatic step();
        bit push, pop;
        logic [32:0] e;
        push = !rst && in_valid && q.size() != DEPTH;
        pop  = !rst && out_ready && q.size() != 0;
        e    = ref_enc(32'(fmt), 32'(opcode), 32'(funct3), 32'(funct7), 32'(rd), 32'(rs1), 32'(rs2), imm);
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            enc_m = 0;
            err_m = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(e);
                if (enc_m < CMAX) enc_m++;
                if (e[32] && err_m < CMAX) err_m++;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; step(); rst = 0;
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] b[14] = '{-2049, -2048, 2047, 2048, -4096, -4098, 4094, 4096,
                               31, 32, -1048576, 1048574, 1048576, -1048578};
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 80)) - 32'd40;
            2: return b[$urandom_range(0, 13)];
            default: return $urandom & 32'hFFFF_F000;
        endcase
    endfunction

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 00000000", instr); end
        if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b exp 0", out_err); end
        if (enc_cnt !== '0) begin errors++; $display("FAIL reset_enc_cnt got %0d exp 0", enc_cnt); end
        if (err_cnt !== '0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
    endtask

    task automatic test_r_type();
        out_ready = 1;
        drive(0, 'h33, 0, 0, 3, 1, 2, 0);
        step();
        checks += 4;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", out_valid); end
        if (instr !== 32'h002081B3) begin errors++; $display("FAIL add_instr got %h exp 002081b3", instr); end
        if (out_err !== 1'b0) begin errors++; $display("FAIL add_err got %b exp 0", out_err); end
        if (enc_cnt !== CW'(1)) begin errors++; $display("FAIL add_enc_cnt got %0d exp 1", enc_cnt); end
        drive(0, 'h33, 0, 'h20, 3, 1, 2, 0);
        step();
        in_valid = 0;
        checks += 2;
        if (instr !== 32'h402081B3) begin errors++; $display("FAIL sub_instr got %h exp 402081b3", instr); end
        if (enc_cnt !== CW'(2)) begin errors++; $display("FAIL sub_enc_cnt got %0d exp 2", enc_cnt); end
        step();
    endtask

    task automatic test_fill_drain();
        logic [31:0] exp_w[4] = '{32'h00500093, 32'h0020A423, 32'h00208463, 32'h123452B7};
        out_ready = 0;
        drive(1, 'h13, 0, 0, 1, 0, 0, 5); step();
        drive(2, 'h23, 2, 0, 0, 1, 2, 8); step();
        drive(3, 'h63, 0, 0, 0, 1, 2, 8); step();
        drive(4, 'h37, 0, 0, 5, 0, 0, 32'h12345000); step();
        in_valid = 0;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL drain%0d_valid got %b exp 1", i, out_valid); end
            if (instr !== exp_w[i]) begin errors++; $display("FAIL drain%0d_instr got %h exp %h", i, instr, exp_w[i]); end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_jal_srai();
        out_ready = 1;
        drive(5, 'h6F, 0, 0, 1, 0, 0, 16); step();
        checks++;
        if (instr !== 32'h010000EF) begin errors++; $display("FAIL jal_instr got %h exp 010000ef", instr); end
        drive(1, 'h13, 5, 'h20, 1, 1, 0, 3); step();
        in_valid = 0;
        checks++;
        if (instr !== 32'h4030D093) begin errors++; $display("FAIL srai_instr got %h exp 4030d093", instr); end
        step();
    endtask

    task automatic test_errors();
        do_reset();
        out_ready = 0;
        drive(3, 'h63, 0, 0, 0, 1, 2, 7); step();
        drive(1, 'h13, 0, 0, 1, 0, 0, 4096); step();
        drive(4, 'h37, 0, 0, 5, 0, 0, 32'h1001); step();
        drive(6, 'h33, 0, 0, 1, 2, 3, 0); step();
        in_valid = 0;
        checks += 2;
        if (err_cnt !== CW'(4)) begin errors++; $display("FAIL err_cnt got %0d exp 4", err_cnt); end
        if (enc_cnt !== CW'(4)) begin errors++; $display("FAIL err_enc_cnt got %0d exp 4", enc_cnt); end
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (instr !== 32'h13) begin errors++; $display("FAIL err%0d_instr got %h exp 00000013", i, instr); end
            if (out_err !== 1'b1) begin errors++; $display("FAIL err%0d_flag got %b exp 1", i, out_err); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int k = 1, seq = 1;
        do_reset();
        out_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(4, 'h37, 0, 0, k % 32, 0, 0, 32'(k) << 12); k++; step();
        end
        out_ready = 1;
        for (int c = 0; c < 4 * DEPTH; c++) begin
            checks += 3;
            if (in_ready !== (q.size() != DEPTH)) begin errors++; $display("FAIL b2b_in_ready c%0d got %b", c, in_ready); end
            if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid c%0d got %b exp 1", c, out_valid); end
            if (instr[31:12] !== 20'(seq)) begin errors++; $display("FAIL b2b_seq c%0d got %0d exp %0d", c, instr[31:12], seq); end
            seq++;
            drive(4, 'h37, 0, 0, k % 32, 0, 0, 32'(k) << 12);
            if (q.size() != DEPTH) k++;
            step();
        end
        in_valid = 0;
        checks++;
        if (seq - 1 < 3 * DEPTH) begin errors++; $display("FAIL b2b_count got %0d exp >=%0d", seq - 1, 3 * DEPTH); end
        while (q.size() != 0) step();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            int f;
            f = $urandom_range(0, 7);
            drive(f, (f == 1 && $urandom_range(0, 1) == 1) ? 'h13 : int'($urandom_range(0, 127)),
                  $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31), rand_imm());
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            step();
            checks += 4;
            if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid c%0d got %b", c, out_valid); end
            if (in_ready !== (q.size() != DEPTH)) begin errors++; $display("FAIL rnd_ready c%0d got %b", c, in_ready); end
            if (enc_cnt !== CW'(enc_m)) begin errors++; $display("FAIL rnd_enc c%0d got %0d exp %0d", c, enc_cnt, enc_m); end
            if (err_cnt !== CW'(err_m)) begin errors++; $display("FAIL rnd_errc c%0d got %0d exp %0d", c, err_cnt, err_m); end
            if (q.size() != 0) begin
                checks++;
                if ({out_err, instr} !== q[0]) begin errors++; $display("FAIL rnd_head c%0d got %b/%h exp %b/%h", c, out_err, instr, q[0][32], q[0][31:0]); end
            end
        end
        checks++;
        if (enc_cnt !== CW'(CMAX)) begin errors++; $display("FAIL rnd_saturate got %0d exp %0d", enc_cnt, CMAX); end
        in_valid = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin drive(1, 'h13, 0, 0, i + 1, 0, 0, i); step(); end
        drive(1, 'h13, 0, 0, 9, 0, 0, 9);
        rst = 1; step(); rst = 0; in_valid = 0;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", in_ready); end
        if (enc_cnt !== '0) begin errors++; $display("FAIL rmid_enc got %0d exp 0", enc_cnt); end
        if (err_cnt !== '0) begin errors++; $display("FAIL rmid_errc got %0d exp 0", err_cnt); end
        drive(0, 'h33, 0, 0, 3, 1, 2, 0); step(); in_valid = 0;
        checks += 2;
        if (instr !== 32'h002081B3) begin errors++; $display("FAIL rmid_head got %h exp 002081b3", instr); end
        if (enc_cnt !== CW'(1)) begin errors++; $display("FAIL rmid_enc1 got %0d exp 1", enc_cnt); end
        out_ready = 1; step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_alone got %b exp 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_fill_drain();
        test_jal_srai();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
